mmio_decoder: RTL and testbench

- Parametrised memory-mapped I/O interconnect between the CPU memory port (valid/ready/wstrb/addr/wdata/rdata) and N peripheral slaves.
- Replaces per-peripheral hand-written valid/ready decode and the ad-hoc ready/rdata priority mux in the SoC top.
- Adds address base/mask decode, a registered response path, a per-access timeout, access-fault signalling and fault bookkeeping.

---
 rtl/mmio_pkg.sv | 10 +
 rtl/mmio_addr_match.sv | 24 ++
 rtl/mmio_decoder.sv | 97 +++++++++
 tb/tb_mmio_decoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared FSM states, fault causes and select-width helper for the MMIO decoder.
package mmio_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;
    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_DECODE  = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;
    function automatic int sel_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mmio_addr_match.sv
// mmio_addr_match: base/mask address comparators with lowest-index priority.
module mmio_addr_match #(
    parameter int N = 4,
    parameter int ADDR_W = 32,
    parameter int SEL_W = 2,
    parameter logic [N*ADDR_W-1:0] BASE = '0,
    parameter logic [N*ADDR_W-1:0] MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [SEL_W-1:0]  sel
);
    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end
endmodule

// File: rtl/mmio_decoder.sv
// mmio_decoder: CPU memory port to N slaves with address decode, timeout and fault bookkeeping.
module mmio_decoder
    import mmio_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
    parameter int TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] FAULT_RDATA = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m_valid,
    input  logic [ADDR_W-1:0]          m_addr,
    input  logic [DATA_W/8-1:0]        m_wstrb,
    input  logic [DATA_W-1:0]          m_wdata,
    output logic                       m_ready,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       m_fault,
    output logic [N_SLAVES-1:0]        s_valid,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W/8-1:0]        s_wstrb,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic [N_SLAVES-1:0]        s_ready,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    output logic [15:0]                fault_count,
    output logic [ADDR_W-1:0]          last_fault_addr
);
    localparam int SW = sel_w(N_SLAVES);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    state_t state, state_n;
    logic [SW-1:0] sel, dec_sel;
    logic hit, rdy, timed_out;
    logic [CW-1:0] cnt;
    logic [1:0] cause;
    logic [DATA_W-1:0] rdata_q;
    mmio_addr_match #(
        .N(N_SLAVES), .ADDR_W(ADDR_W), .SEL_W(SW), .BASE(SLAVE_BASE), .MASK(SLAVE_MASK)
    ) u_match (
        .addr(m_addr), .hit(hit), .sel(dec_sel)
    );
    assign rdy = state == ACTIVE && s_ready[sel];
    assign timed_out = cnt == CW'(TIMEOUT_CYCLES - 1);
    assign m_ready = state == RESP;
    assign m_fault = m_ready && cause != FAULT_NONE;
    assign m_rdata = m_ready ? rdata_q : '0;
    // Valid drops in the same cycle the selected slave answers.
    always_comb begin
        s_valid = '0;
        if (state == ACTIVE) s_valid[sel] = !s_ready[sel];
    end
    always_comb begin
        state_n = state == IDLE   ? (m_valid ? (hit ? ACTIVE : RESP) : IDLE) :
                  state == ACTIVE ? ((rdy || timed_out) ? RESP : ACTIVE) : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            s_addr <= '0;
            s_wstrb <= '0;
            s_wdata <= '0;
            sel <= '0;
            cnt <= '0;
            cause <= FAULT_NONE;
            rdata_q <= '0;
            fault_count <= '0;
            last_fault_addr <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && m_valid) begin
                s_addr <= m_addr;
                s_wstrb <= m_wstrb;
                s_wdata <= m_wdata;
                sel <= dec_sel;
                cnt <= '0;
                cause <= hit ? FAULT_NONE : FAULT_DECODE;
                rdata_q <= hit ? '0 : FAULT_RDATA;
            end
            if (state == ACTIVE) begin
                cnt <= cnt + 1'b1;
                if (rdy) begin
                    rdata_q <= s_rdata[sel*DATA_W +: DATA_W];
                    cause <= FAULT_NONE;
                end else if (timed_out) begin
                    rdata_q <= FAULT_RDATA;
                    cause <= FAULT_TIMEOUT;
                end
            end
            if (state == RESP && cause != FAULT_NONE) begin
                if (fault_count != 16'hFFFF) fault_count <= fault_count + 1'b1;
                last_fault_addr <= s_addr;
            end
        end
    end
endmodule

// File: tb/tb_mmio_decoder.sv
// tb_mmio_decoder: directed vector table plus hand sequences for reset abort and saturation.
module tb_mmio_decoder;
    logic clk = 0, reset = 1;
    logic m_valid = 0, m_ready, m_fault;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata, s_addr, s_wdata, last_fault_addr;
    logic [3:0] m_wstrb = 0, s_wstrb;
    logic [2:0] s_valid, s_ready = 0;
    logic [95:0] s_rdata = 0;
    logic [15:0] fault_count;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;

    mmio_decoder #(
        .N_SLAVES(3), .ADDR_W(32), .DATA_W(32),
        .SLAVE_BASE({32'h1100_0000, 32'h1000_0000, 32'h8000_0000}),
        .SLAVE_MASK({32'hFFFF_0000, 32'hFFFF_FFF0, 32'hF000_0000}),
        .TIMEOUT_CYCLES(8), .FAULT_RDATA(32'h0)
    ) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_addr(m_addr), .m_wstrb(m_wstrb),
        .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata), .m_fault(m_fault),
        .s_valid(s_valid), .s_addr(s_addr), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata), .fault_count(fault_count),
        .last_fault_addr(last_fault_addr)
    );

    typedef struct {
        logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata;
        int sidx; int delay; int spur; logic [31:0] srdata;
        logic [2:0] exp_sv; int exp_lat; logic exp_fault; logic [31:0] exp_rdata;
        logic [15:0] exp_fc; logic [31:0] exp_lfa;
    } vec_t;
    vec_t v[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // delay = cycles after the request cycle at which the slave answers; -1 = never
    task automatic run_vec(input vec_t t);
        logic [2:0] sv_or = 0;
        int sv_cyc = 0;
        logic done = 0;
        @(negedge clk);
        m_valid = 1; m_addr = t.addr; m_wstrb = t.wstrb; m_wdata = t.wdata;
        for (int j = 0; j < 3; j++)
            s_rdata[j*32 +: 32] = (j == t.sidx) ? t.srdata : 32'hBAD0_0000 + j;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            s_ready = 0;
            if (n == 0) begin
                check("s_addr", s_addr, t.addr);
                check("s_wstrb", {28'd0, s_wstrb}, {28'd0, t.wstrb});
                check("s_wdata", s_wdata, t.wdata);
            end
            if (m_ready) begin
                done = 1;
                m_valid = 0;
                check("latency", n, t.exp_lat);
                check("m_fault", {31'd0, m_fault}, {31'd0, t.exp_fault});
                check("m_rdata", m_rdata, t.exp_rdata);
            end else begin
                sv_or |= s_valid;
                if (s_valid != 0) sv_cyc++;
                if (n == 1 && t.spur >= 0) s_ready[t.spur] = 1;
                if (n == t.delay) begin
                    s_ready[t.sidx] = 1;
                    #1 check("valid_drop", {29'd0, s_valid}, 32'd0);
                end
            end
        end
        check("resp_seen", {31'd0, done}, 32'd1);
        m_valid = 0;
        check("s_valid_seen", {29'd0, sv_or}, {29'd0, t.exp_sv});
        check("s_valid_cycles", sv_cyc, t.exp_lat);
        @(negedge clk);
        check("m_ready_pulse", {31'd0, m_ready}, 32'd0);
        check("fault_count", {16'd0, fault_count}, {16'd0, t.exp_fc});
        check("last_fault_addr", last_fault_addr, t.exp_lfa);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        vec_t mv;
        v[0] = '{32'h8000_0010, 4'h0, 32'h0, 0, 2, -1, 32'hDEAD_BEEF, 3'b001, 3, 0, 32'hDEAD_BEEF, 16'd0, 32'h0};
        v[1] = '{32'h1000_0004, 4'h1, 32'h41, 1, 0, -1, 32'h0000_1234, 3'b010, 1, 0, 32'h0000_1234, 16'd0, 32'h0};
        v[2] = '{32'h2000_0000, 4'h0, 32'h0, 0, -1, -1, 32'h0, 3'b000, 0, 1, 32'h0, 16'd1, 32'h2000_0000};
        v[3] = '{32'h1100_0000, 4'h0, 32'h0, 2, -1, -1, 32'h5555_AAAA, 3'b100, 8, 1, 32'h0, 16'd2, 32'h1100_0000};
        v[4] = '{32'h1000_0008, 4'h0, 32'h0, 1, 3, 0, 32'hCAFE_F00D, 3'b010, 4, 0, 32'hCAFE_F00D, 16'd2, 32'h1100_0000};
        v[5] = '{32'h1000_0010, 4'hF, 32'hFFFF_FFFF, 1, -1, -1, 32'h0, 3'b000, 0, 1, 32'h0, 16'd3, 32'h1000_0010};
        v[6] = '{32'h1100_ABCC, 4'h0, 32'h0, 2, 7, -1, 32'h1357_9BDF, 3'b100, 8, 0, 32'h1357_9BDF, 16'd3, 32'h1000_0010};
        v[7] = '{32'h8FFF_FFFC, 4'h3, 32'hAA55, 0, 1, -1, 32'h0246_8ACE, 3'b001, 2, 0, 32'h0246_8ACE, 16'd3, 32'h1000_0010};

        repeat (2) @(negedge clk);
        check("rst_m_ready", {31'd0, m_ready}, 32'd0);
        check("rst_m_fault", {31'd0, m_fault}, 32'd0);
        check("rst_m_rdata", m_rdata, 32'd0);
        check("rst_s_valid", {29'd0, s_valid}, 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        check("rst_fault_count", {16'd0, fault_count}, 32'd0);
        check("rst_last_fault_addr", last_fault_addr, 32'd0);
        reset = 0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(v[i]);

        s_ready = 3'b111;
        @(negedge clk);
        check("idle_ready_m_ready", {31'd0, m_ready}, 32'd0);
        check("idle_ready_s_valid", {29'd0, s_valid}, 32'd0);
        s_ready = 0;
        @(negedge clk);
        check("idle_ready_no_resp", {31'd0, m_ready}, 32'd0);

        m_valid = 1; m_addr = 32'h8000_0000; m_wstrb = 0;
        @(negedge clk);
        check("abort_active_valid", {29'd0, s_valid}, 32'd1);
        m_valid = 0;
        @(negedge clk);
        #2 reset = 1;
        #1;
        check("abort_m_ready", {31'd0, m_ready}, 32'd0);
        check("abort_s_valid", {29'd0, s_valid}, 32'd0);
        check("abort_s_addr", s_addr, 32'd0);
        check("abort_fault_count", {16'd0, fault_count}, 32'd0);
        check("abort_last_fault_addr", last_fault_addr, 32'd0);
        @(negedge clk);
        reset = 0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (m_ready) seen = 1;
        end
        check("abort_no_resp", {31'd0, seen}, 32'd0);

        @(negedge clk);
        force dut.fault_count = 16'hFFFC;
        @(negedge clk);
        release dut.fault_count;
        @(negedge clk);
        check("preload_fault_count", {16'd0, fault_count}, 32'h0000_FFFC);
        mv = v[2];
        for (int k = 1; k <= 5; k++) begin
            mv.exp_fc = (k >= 3) ? 16'hFFFF : 16'hFFFC + 16'(k);
            run_vec(mv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
